// File: rtl/param_ring_counter_if.sv
// Control/status bundle for param_ring_counter: step/load controls in, counter state and pulses out.
interface param_ring_counter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [1:0]       mode;
    logic [WIDTH-1:0] Y;
    logic             wrap;
    logic [CNT_W-1:0] rev_count;
    logic             illegal;

    modport master (
        output en, load, load_data, mode,
        input  Y, wrap, rev_count, illegal
    );

    modport slave (
        input  en, load, load_data, mode,
        output Y, wrap, rev_count, illegal
    );
endinterface

// File: rtl/param_ring_counter.sv
// Parametrised ring/Johnson counter with parallel load, wrap pulse and revolution count.
// Optional one-hot self-correction in rotate modes: define PARAM_RING_COUNTER_SELFCORRECT_EN.
module param_ring_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1),
    parameter int               CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    param_ring_counter_if.slave  bus
);
    localparam int STEP_W = $clog2(2 * WIDTH);

    logic [WIDTH-1:0]  r_y;
    logic [STEP_W-1:0] r_step;
    logic [1:0]        r_mode_q;
    logic              r_wrap;
    logic [CNT_W-1:0]  r_rev_count;
    logic              r_illegal;

    logic [WIDTH-1:0]  w_shift;
    logic [STEP_W-1:0] w_last;
    logic              w_correct;

    always_comb begin
        w_shift = r_y;
        case (bus.mode)
            2'b00: w_shift = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
            2'b01: w_shift = {r_y[0], r_y[WIDTH-1:1]};
            2'b10: w_shift = {r_y[WIDTH-2:0], ~r_y[WIDTH-1]};
            2'b11: w_shift = {~r_y[0], r_y[WIDTH-1:1]};
            default: w_shift = r_y;
        endcase
    end

    // Period is WIDTH for rotate modes, 2*WIDTH for Johnson modes.
    assign w_last = bus.mode[1] ? STEP_W'(2 * WIDTH - 1) : STEP_W'(WIDTH - 1);

`ifdef PARAM_RING_COUNTER_SELFCORRECT_EN
    logic w_onehot;
    assign w_onehot  = (r_y != '0) && ((r_y & (r_y - WIDTH'(1))) == '0);
    assign w_correct = ~bus.mode[1] & ~w_onehot;
`else
    assign w_correct = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y         <= RESET_VALUE;
            r_step      <= '0;
            r_mode_q    <= 2'b00;
            r_wrap      <= 1'b0;
            r_rev_count <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
            if (bus.load) begin
                r_y      <= bus.load_data;
                r_step   <= '0;
                r_mode_q <= bus.mode;
            end else if (bus.en) begin
                r_mode_q <= bus.mode;
                if (w_correct) begin
                    r_y       <= RESET_VALUE;
                    r_step    <= '0;
                    r_illegal <= 1'b1;
                end else begin
                    r_y <= w_shift;
                    // A mode change restarts the period with this shift as its first step.
                    if (bus.mode != r_mode_q) begin
                        r_step <= STEP_W'(1);
                    end else if (r_step == w_last) begin
                        r_step      <= '0;
                        r_wrap      <= 1'b1;
                        r_rev_count <= r_rev_count + CNT_W'(1);
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
            end
        end
    end

    assign bus.Y         = r_y;
    assign bus.wrap      = r_wrap;
    assign bus.rev_count = r_rev_count;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_param_ring_counter.sv
// Bench for param_ring_counter (WIDTH=4): behavioural model checked every cycle plus directed literals.
module tb_param_ring_counter;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int RV   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cmp_on = 1'b0;

    param_ring_counter_if #(.WIDTH(W), .CNT_W(8)) bus ();

    param_ring_counter #(.WIDTH(W), .RESET_VALUE(4'b0001), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: steps counted since the last sync point (reset/load/mode change/correction).
    int m_y, m_since, m_mode, m_rev;
    bit m_wrap, m_ill;

    function automatic int shift_of(input int y, input int md);
        case (md)
            0: return ((y << 1) | (y >> (W - 1))) & MASK;
            1: return (y >> 1) | ((y & 1) << (W - 1));
            2: return ((y << 1) & MASK) | (((y >> (W - 1)) & 1) ^ 1);
            default: return (y >> 1) | (((y & 1) ^ 1) << (W - 1));
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y = RV; m_since = 0; m_mode = 0; m_rev = 0; m_wrap = 0; m_ill = 0;
        end else begin
            int p;
            int md;
            md = int'(bus.mode);
            p  = (md >= 2) ? 2 * W : W;
            m_wrap = 0;
            m_ill  = 0;
            if (bus.load) begin
                m_y = int'(bus.load_data); m_since = 0; m_mode = md;
            end else if (bus.en) begin
`ifdef PARAM_RING_COUNTER_SELFCORRECT_EN
                if (md < 2 && $countones(m_y) != 1) begin
                    m_y = RV; m_since = 0; m_mode = md; m_ill = 1;
                end else
`endif
                begin
                    m_y = shift_of(m_y, md);
                    if (md != m_mode) begin
                        m_mode = md; m_since = 1;
                    end else begin
                        m_since++;
                        if (m_since == p) begin
                            m_since = 0; m_wrap = 1; m_rev = (m_rev + 1) % 256;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("model_Y", int'(bus.Y), m_y);
            chk("model_wrap", int'(bus.wrap), int'(m_wrap));
            chk("model_rev", int'(bus.rev_count), m_rev);
            chk("model_illegal", int'(bus.illegal), int'(m_ill));
        end
    end

    task automatic tick(input bit e, input bit ld, input logic [3:0] d, input logic [1:0] md);
        @(negedge clk);
        bus.en = e; bus.load = ld; bus.load_data = d; bus.mode = md;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp1 [8] = '{2, 4, 8, 1, 2, 4, 8, 1};
        int exp2 [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
        bus.en = 0; bus.load = 0; bus.load_data = '0; bus.mode = 2'b00;
        #12;
        chk("reset_Y", int'(bus.Y), 1);
        chk("reset_wrap", int'(bus.wrap), 0);
        chk("reset_rev", int'(bus.rev_count), 0);
        chk("reset_illegal", int'(bus.illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Rotate left from reset
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 4'h0, 2'b00);
            chk($sformatf("rotl_Y%0d", i), int'(bus.Y), exp1[i]);
            chk($sformatf("rotl_wrap%0d", i), int'(bus.wrap), (i == 3 || i == 7) ? 1 : 0);
        end
        chk("rotl_rev", int'(bus.rev_count), 2);

        // Johnson left from 0000
        tick(0, 1, 4'h0, 2'b10);
        chk("jl_load", int'(bus.Y), 0);
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 4'h0, 2'b10);
            chk($sformatf("jl_Y%0d", i), int'(bus.Y), exp2[i]);
            chk($sformatf("jl_wrap%0d", i), int'(bus.wrap), (i == 7) ? 1 : 0);
        end
        chk("jl_rev", int'(bus.rev_count), 3);

        // Load beats en
        tick(1, 1, 4'b0100, 2'b10);
        chk("ld_en_Y", int'(bus.Y), 4);
        chk("ld_en_wrap", int'(bus.wrap), 0);

        // Hold
        tick(0, 0, 4'hf, 2'b01);
        chk("hold_Y", int'(bus.Y), 4);
        chk("hold_wrap", int'(bus.wrap), 0);

        // Mode change mid-period
        tick(0, 1, 4'b0001, 2'b00);
        tick(1, 0, 4'h0, 2'b00);
        tick(1, 0, 4'h0, 2'b00);
        chk("mc_pre", int'(bus.Y), 4);
        tick(1, 0, 4'h0, 2'b01);
        chk("mc_Y", int'(bus.Y), 2);
        chk("mc_wrap1", int'(bus.wrap), 0);
        tick(1, 0, 4'h0, 2'b01);
        chk("mc_wrap2", int'(bus.wrap), 0);
        tick(1, 0, 4'h0, 2'b01);
        chk("mc_wrap3", int'(bus.wrap), 0);
        tick(1, 0, 4'h0, 2'b01);
        chk("mc_wrap4", int'(bus.wrap), 1);
        chk("mc_Y4", int'(bus.Y), 4);

        // Async reset between edges with en high
        tick(1, 0, 4'h0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_Y", int'(bus.Y), 1);
        chk("areset_rev", int'(bus.rev_count), 0);
        chk("areset_wrap", int'(bus.wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-one-hot value in rotate mode
        tick(0, 1, 4'b0110, 2'b00);
        tick(1, 0, 4'h0, 2'b00);
`ifdef PARAM_RING_COUNTER_SELFCORRECT_EN
        chk("sc_Y", int'(bus.Y), 1);
        chk("sc_illegal", int'(bus.illegal), 1);
`else
        chk("sc_Y", int'(bus.Y), 12);
        chk("sc_illegal", int'(bus.illegal), 0);
`endif
        tick(1, 0, 4'h0, 2'b00);
        chk("sc_illegal_pulse", int'(bus.illegal), 0);

        // rev_count rolls over at 256 periods
        tick(0, 0, 4'h0, 2'b00);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4 * 256; i++) tick(1, 0, 4'h0, 2'b00);
        chk("rev_rollover", int'(bus.rev_count), 0);
        chk("rev_roll_Y", int'(bus.Y), 1);
        chk("rev_roll_wrap", int'(bus.wrap), 1);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
